// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial RISC-V load/store stage (LB/LH/LW/LBU/LHU/SB/SH/SW).
// One byte per memory handshake, little-endian, address wraps at 2^ADDRESS_WIDTH.
// Optional build macro MISALIGNED_ACCESS_EN: when defined, misaligned halfwords and
// words are carried out byte-by-byte instead of being rejected.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     request_valid,
  output logic                     request_ready,
  input  logic                     is_store,
  input  logic [2:0]               funct3,
  input  logic [31:0]              address,
  input  logic [31:0]              store_data,
  output logic                     response_valid,
  output logic [31:0]              load_data,
  output logic                     misaligned,
  output logic                     mem_request,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [7:0]               mem_write_data,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     is_store_q, is_store_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [31:0]              store_data_q, store_data_d;
  logic [1:0]               idx_q, idx_d;
  logic [31:0]              raw_q, raw_d;
  logic [31:0]              load_data_q, load_data_d;
  logic                     misaligned_q, misaligned_d;
  logic                     unused_s;

  // Index of the final byte of the access: 0 (byte), 1 (half), 3 (word).
  function automatic logic [1:0] last_index(input logic [2:0] f3);
    logic [1:0] idx;
    idx = 2'd3;
    case (f3[1:0])
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Halfword on an odd address or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Sign- or zero-extend the assembled bytes; words pass through unchanged.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] f3);
    logic [31:0] ext;
    ext = raw;
    case (f3[1:0])
      2'b00:   ext = {{24{raw[7] & ~f3[2]}}, raw[7:0]};
      2'b01:   ext = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  // Next-state and datapath update: accept in Idle, one byte per ack in Access.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    base_d       = base_q;
    store_data_d = store_data_q;
    idx_d        = idx_q;
    raw_d        = raw_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    case (state_q)
      ST_IDLE: begin
        if (request_valid) begin
          is_store_d   = is_store;
          funct3_d     = funct3;
          base_d       = address[ADDRESS_WIDTH-1:0];
          store_data_d = store_data;
          idx_d        = 2'd0;
          raw_d        = 32'd0;
          load_data_d  = 32'd0;
`ifdef MISALIGNED_ACCESS_EN
          misaligned_d = 1'b0;
`else
          misaligned_d = is_misaligned(funct3, address[1:0]);
`endif
          state_d      = misaligned_d ? ST_RESPOND : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          if (!is_store_q) begin
            raw_d[{idx_q, 3'b000} +: 8] = mem_read_data;
          end else begin
            raw_d = raw_q;
          end
          if (idx_q == last_index(funct3_q)) begin
            state_d = ST_RESPOND;
            if (!is_store_q) begin
              load_data_d = extend_load(raw_d, funct3_q);
            end else begin
              load_data_d = 32'd0;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      base_q       <= '0;
      store_data_q <= 32'd0;
      idx_q        <= 2'd0;
      raw_q        <= 32'd0;
      load_data_q  <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      base_q       <= base_d;
      store_data_q <= store_data_d;
      idx_q        <= idx_d;
      raw_q        <= raw_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Output decode straight from registered state; bus fields forced to 0 when idle.
  always_comb begin
    request_ready  = (state_q == ST_IDLE);
    response_valid = (state_q == ST_RESPOND);
    mem_request    = (state_q == ST_ACCESS);
    mem_write      = mem_request & is_store_q;
    load_data      = load_data_q;
`ifdef MISALIGNED_ACCESS_EN
    misaligned     = 1'b0;
`else
    misaligned     = response_valid & misaligned_q;
`endif
    if (mem_request) begin
      mem_address    = base_q + {{(ADDRESS_WIDTH-2){1'b0}}, idx_q};
      mem_write_data = store_data_q[{idx_q, 3'b000} +: 8];
    end else begin
      mem_address    = '0;
      mem_write_data = 8'd0;
    end
  end

  // Address bits above the external bus width are deliberately dropped.
`ifdef MISALIGNED_ACCESS_EN
  assign unused_s = ^{address[31:ADDRESS_WIDTH], misaligned_q};
`else
  assign unused_s = ^address[31:ADDRESS_WIDTH];
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a byte-wide memory responder.
module tb_load_store_unit;

`ifdef MISALIGNED_ACCESS_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        request_valid = 1'b0;
  logic        request_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        response_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        mem_request;
  logic        mem_write;
  logic [23:0] mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_read_data = 8'd0;

  load_store_unit #(.ADDRESS_WIDTH(24)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .is_store(is_store), .funct3(funct3), .address(address), .store_data(store_data),
    .response_valid(response_valid), .load_data(load_data), .misaligned(misaligned),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_ack(mem_ack), .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  // Memory image (read-only to the responder) and transfer log.
  logic [7:0]  mem [0:1023];
  int          ack_delay = 0;
  logic [23:0] log_addr[$];
  logic [7:0]  log_data[$];
  bit          log_we[$];
  bit          log_stable[$];

  // Responder: acks each byte after ack_delay waiting cycles, logs every transfer.
  always @(negedge clock) begin
    static int          wait_cnt = 0;
    static logic [23:0] hold_addr = 24'd0;
    static bit          stable = 1'b1;
    if (mem_request && !reset) begin
      if (wait_cnt == 0) begin
        hold_addr = mem_address;
        stable    = 1'b1;
      end else if (mem_address !== hold_addr) begin
        stable = 1'b0;
      end
      if (wait_cnt == ack_delay) begin
        mem_ack       = 1'b1;
        mem_read_data = mem[mem_address[9:0]];
        log_addr.push_back(mem_address);
        log_data.push_back(mem_write ? mem_write_data : mem[mem_address[9:0]]);
        log_we.push_back(mem_write);
        log_stable.push_back(stable);
        wait_cnt = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    int          dly;
    logic [31:0] exp_load;
    bit          exp_mis;
    int          exp_n;
  } vec_t;

  function automatic vec_t mk(input string name, input bit st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata, input int dly,
                              input logic [31:0] exp_load, input bit exp_mis, input int exp_n);
    vec_t v;
    v.name = name; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.dly = dly;
    v.exp_load = exp_load; v.exp_mis = exp_mis; v.exp_n = exp_n;
    return v;
  endfunction

  // Issue one request, wait for the response, then check timing, data and bus log.
  task automatic run_vec(input vec_t v);
    int          cycles;
    int          base_idx;
    int          ntrans;
    int          exp_lat;
    logic [23:0] ea;
    logic [31:0] sd;
    ack_delay = v.dly;
    @(negedge clock);
    check({v.name, "/ready_idle"}, 32'(request_ready), 32'd1);
    request_valid = 1'b1;
    is_store      = v.st;
    funct3        = v.f3;
    address       = v.addr;
    store_data    = v.sdata;
    base_idx      = log_addr.size();
    @(posedge clock); #1;
    request_valid = 1'b0;
    is_store      = ~v.st;
    funct3        = ~v.f3;
    address       = ~v.addr;
    store_data    = ~v.sdata;
    cycles = 0;
    while (!response_valid && cycles < 200) begin
      @(posedge clock); #1;
      cycles++;
    end
    exp_lat = v.exp_mis ? 0 : v.exp_n * (v.dly + 1);
    check({v.name, "/resp_seen"}, 32'(response_valid), 32'd1);
    check({v.name, "/latency"}, 32'(cycles), 32'(exp_lat));
    check({v.name, "/load_data"}, load_data, v.exp_load);
    check({v.name, "/misaligned"}, 32'(misaligned), 32'(v.exp_mis));
    check({v.name, "/ready_busy"}, 32'(request_ready), 32'd0);
    ntrans = log_addr.size() - base_idx;
    check({v.name, "/n_bytes"}, 32'(ntrans), 32'(v.exp_n));
    sd = v.sdata;
    for (int j = 0; j < ntrans && j < 4; j++) begin
      ea = v.addr[23:0] + 24'(j);
      check({v.name, "/addr"}, 32'(log_addr[base_idx + j]), 32'(ea));
      check({v.name, "/we"}, 32'(log_we[base_idx + j]), 32'(v.st));
      check({v.name, "/stable"}, 32'(log_stable[base_idx + j]), 32'd1);
      if (v.st) check({v.name, "/wdata"}, 32'(log_data[base_idx + j]), 32'(sd[8*j +: 8]));
    end
    @(posedge clock); #1;
    check({v.name, "/resp_pulse"}, 32'(response_valid), 32'd0);
    check({v.name, "/mis_quiet"}, 32'(misaligned), 32'd0);
    check({v.name, "/load_hold"}, load_data, v.exp_load);
  endtask

  vec_t vecs[13];

  initial begin
    int base_idx;
    int seen;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    mem[10'h104] = 8'h9A; mem[10'h105] = 8'hBC; mem[10'h106] = 8'hDE; mem[10'h107] = 8'hF0;
    mem[10'h010] = 8'h80; mem[10'h011] = 8'h7F;

    vecs[0]  = mk("lw_100",   1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'h1234_5678, 1'b0, 4);
    vecs[1]  = mk("lb_10",    1'b0, 3'b000, 32'h0000_0010, 32'h0, 0, 32'hFFFF_FF80, 1'b0, 1);
    vecs[2]  = mk("lbu_10",   1'b0, 3'b100, 32'h0000_0010, 32'h0, 0, 32'h0000_0080, 1'b0, 1);
    vecs[3]  = mk("sh_20",    1'b1, 3'b001, 32'h0000_0020, 32'hDEAD_BEEF, 3, 32'h0, 1'b0, 2);
    vecs[4]  = MIS_EN ? mk("lw_102", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'hBC9A_1234, 1'b0, 4)
                      : mk("lw_102", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h0, 1'b1, 0);
    vecs[5]  = mk("lh_104",   1'b0, 3'b001, 32'h0000_0104, 32'h0, 0, 32'hFFFF_BC9A, 1'b0, 2);
    vecs[6]  = mk("lhu_104",  1'b0, 3'b101, 32'h0000_0104, 32'h0, 1, 32'h0000_BC9A, 1'b0, 2);
    vecs[7]  = mk("lwu_104",  1'b0, 3'b110, 32'h0000_0104, 32'h0, 0, 32'hF0DE_BC9A, 1'b0, 4);
    vecs[8]  = MIS_EN ? mk("lh_101", 1'b0, 3'b001, 32'h0000_0101, 32'h0, 0, 32'h0000_3456, 1'b0, 2)
                      : mk("lh_101", 1'b0, 3'b001, 32'h0000_0101, 32'h0, 0, 32'h0, 1'b1, 0);
    vecs[9]  = MIS_EN ? mk("sw_wrap", 1'b1, 3'b010, 32'h00FF_FFFE, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 4)
                      : mk("sw_wrap", 1'b1, 3'b010, 32'h00FF_FFFE, 32'hCAFE_F00D, 0, 32'h0, 1'b1, 0);
    vecs[10] = mk("lb_hiaddr", 1'b0, 3'b000, 32'hFF00_0010, 32'h0, 0, 32'hFFFF_FF80, 1'b0, 1);
    vecs[11] = mk("sb_3",     1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 1, 32'h0, 1'b0, 1);
    vecs[12] = mk("lh_10",    1'b0, 3'b001, 32'h0000_0010, 32'h0, 2, 32'h0000_7F80, 1'b0, 2);

    // Reset state.
    #1 reset = 1'b1;
    #2;
    check("rst/response_valid", 32'(response_valid), 32'd0);
    check("rst/misaligned", 32'(misaligned), 32'd0);
    check("rst/mem_request", 32'(mem_request), 32'd0);
    check("rst/mem_write", 32'(mem_write), 32'd0);
    check("rst/load_data", load_data, 32'd0);
    check("rst/mem_address", 32'(mem_address), 32'd0);
    check("rst/mem_write_data", 32'(mem_write_data), 32'd0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    check("rst/request_ready", 32'(request_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset after the second byte of a word load aborts it with no response.
    ack_delay = 0;
    @(negedge clock);
    request_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; address = 32'h0000_0100;
    base_idx = log_addr.size();
    @(posedge clock); #1;
    request_valid = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    check("abort/busy_before", 32'(mem_request), 32'd1);
    reset = 1'b1;
    #1;
    check("abort/mem_request", 32'(mem_request), 32'd0);
    check("abort/response_valid", 32'(response_valid), 32'd0);
    check("abort/mem_address", 32'(mem_address), 32'd0);
    @(negedge clock); reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (response_valid) seen++;
    end
    check("abort/no_response", 32'(seen), 32'd0);
    check("abort/bytes_done", 32'(log_addr.size() - base_idx), 32'd2);
    run_vec(mk("lb_after_abort", 1'b0, 3'b000, 32'h0000_0010, 32'h0, 0, 32'hFFFF_FF80, 1'b0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
